time_set_ctrl: RTL and testbench

Key-driven time-setting controller for the digital clock. It sits between the debounced key block and the BCD counter chain (seconds, minutes, hours). It captures the running time, lets the user edit the hour, minute and second fields in turn with increment and decrement keys, and drives the counters' set-mode and set values. It also drives a blink phase to the display.

---
 rtl/clock_pkg.sv | 32 +++
 rtl/bcd_field_adj.sv | 42 ++++
 rtl/time_set_ctrl.sv | 178 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types for the digital clock: set-controller state codes,
// field codes, BCD field limits and a capture clamp helper.
package clock_pkg;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_SET_HOUR,
      ST_SET_MIN,
      ST_SET_SEC,
      ST_COMMIT
   } state_t;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HOUR = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_SEC  = 2'd3;

   localparam logic [7:0] HOUR_MAX_BCD   = 8'h23;
   localparam logic [7:0] MINSEC_MAX_BCD = 8'h59;

   // Illegal digits or out-of-range values collapse to 00.
   // Once both digits are legal, BCD compares like binary.
   function automatic logic [7:0] bcd_clamp(
      input logic [7:0] v,
      input logic [7:0] max
   );
      if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max)
         return 8'h00;
      return v;
   endfunction

endpackage

// File: rtl/bcd_field_adj.sv
// Two-digit BCD increment/decrement with wrap at 00 / max.
// Ports: val (BCD in), inc, dec, max (BCD limit), nxt (BCD out).
module bcd_field_adj
   import clock_pkg::*;
(
   input  logic [7:0] val,
   input  logic       inc,
   input  logic       dec,
   input  logic [7:0] max,
   output logic [7:0] nxt
);

   logic up;
   logic dn;

   assign up = inc & ~dec;
   assign dn = dec & ~inc;

   always_comb begin
      nxt = val;
      unique case (1'b1)
         up: begin
            if (val >= max)
               nxt = 8'h00;
            else if (val[3:0] == 4'd9)
               nxt = {val[7:4] + 4'd1, 4'd0};
            else
               nxt = {val[7:4], val[3:0] + 4'd1};
         end
         dn: begin
            if (val == 8'h00)
               nxt = max;
            else if (val[3:0] == 4'd0)
               nxt = {val[7:4] - 4'd1, 4'd9};
            else
               nxt = {val[7:4], val[3:0] - 4'd1};
         end
         default: nxt = val;
      endcase
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Key-driven time-setting controller: captures the running time,
// edits hour/minute/second fields, commits with a load pulse.
// Ports: clk, rst_n (async low), tick_1hz, key_mode/inc/dec pulses,
//   hour1..sec0 current BCD time; set_mode, load, *_set* edited BCD,
//   field (0 none,1 h,2 m,3 s), blink.
// Option: SET_TIMEOUT_EN adds auto-commit after TIMEOUT_S idle seconds.
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int TIMEOUT_S = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       key_mode,
   input  logic       key_inc,
   input  logic       key_dec,
   input  logic [3:0] hour1,
   input  logic [3:0] hour0,
   input  logic [3:0] min1,
   input  logic [3:0] min0,
   input  logic [3:0] sec1,
   input  logic [3:0] sec0,
   output logic       set_mode,
   output logic       load,
   output logic [3:0] hour_set1,
   output logic [3:0] hour_set0,
   output logic [3:0] min_set1,
   output logic [3:0] min_set0,
   output logic [3:0] sec_set1,
   output logic [3:0] sec_set0,
   output logic [1:0] field,
   output logic       blink
);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] hour_r, min_r, sec_r;
   logic [7:0] hour_nx, min_nx, sec_nx;
   logic       ed_inc, ed_dec;
   logic       any_key;
   logic       capture;
   logic       in_set;
   logic       in_set_nxt;
   logic       timeout;

   assign any_key = key_mode | key_inc | key_dec;
   assign capture = (state == ST_RUN) & key_mode;
   assign in_set  = (state == ST_SET_HOUR) |
                    (state == ST_SET_MIN)  |
                    (state == ST_SET_SEC);

   // key_mode takes the cycle; inc/dec are dropped with it
   assign ed_inc = key_inc & ~key_mode;
   assign ed_dec = key_dec & ~key_mode;

`ifdef SET_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_S + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_S - 1);

   logic [CW-1:0] idle_cnt;

   // Fires on the tick that would bring the count to TIMEOUT_S
   assign timeout = in_set & tick_1hz & (idle_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         idle_cnt <= '0;
      else if (capture || (in_set && any_key))
         idle_cnt <= '0;
      else if (in_set && tick_1hz)
         idle_cnt <= idle_cnt + CW'(1);
   end
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_S;
   assign timeout = 1'b0;
`endif

   bcd_field_adj u_hour (
      .val (hour_r),
      .inc (ed_inc & (state == ST_SET_HOUR)),
      .dec (ed_dec & (state == ST_SET_HOUR)),
      .max (HOUR_MAX_BCD),
      .nxt (hour_nx)
   );

   bcd_field_adj u_min (
      .val (min_r),
      .inc (ed_inc & (state == ST_SET_MIN)),
      .dec (ed_dec & (state == ST_SET_MIN)),
      .max (MINSEC_MAX_BCD),
      .nxt (min_nx)
   );

   bcd_field_adj u_sec (
      .val (sec_r),
      .inc (ed_inc & (state == ST_SET_SEC)),
      .dec (ed_dec & (state == ST_SET_SEC)),
      .max (MINSEC_MAX_BCD),
      .nxt (sec_nx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_RUN:      if (key_mode) state_nxt = ST_SET_HOUR;
         ST_SET_HOUR: if (key_mode) state_nxt = ST_SET_MIN;
         ST_SET_MIN:  if (key_mode) state_nxt = ST_SET_SEC;
         ST_SET_SEC:  if (key_mode) state_nxt = ST_COMMIT;
         ST_COMMIT:   state_nxt = ST_RUN;
         default:     state_nxt = ST_RUN;
      endcase
      if (timeout)
         state_nxt = ST_COMMIT;
   end

   always_comb begin
      set_mode = 1'b0;
      load     = 1'b0;
      field    = FIELD_NONE;
      unique case (state)
         ST_SET_HOUR: begin set_mode = 1'b1; field = FIELD_HOUR; end
         ST_SET_MIN:  begin set_mode = 1'b1; field = FIELD_MIN;  end
         ST_SET_SEC:  begin set_mode = 1'b1; field = FIELD_SEC;  end
         ST_COMMIT:   begin set_mode = 1'b1; load  = 1'b1;       end
         default:     ;
      endcase
   end

   // Unselected adjusters pass their value through unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hour_r <= 8'h00;
         min_r  <= 8'h00;
         sec_r  <= 8'h00;
      end else if (capture) begin
         hour_r <= bcd_clamp({hour1, hour0}, HOUR_MAX_BCD);
         min_r  <= bcd_clamp({min1, min0}, MINSEC_MAX_BCD);
         sec_r  <= bcd_clamp({sec1, sec0}, MINSEC_MAX_BCD);
      end else begin
         hour_r <= hour_nx;
         min_r  <= min_nx;
         sec_r  <= sec_nx;
      end
   end

   assign in_set_nxt = (state_nxt == ST_SET_HOUR) |
                       (state_nxt == ST_SET_MIN)  |
                       (state_nxt == ST_SET_SEC);

   // Any key shows the field solidly; ticks toggle it while editing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         blink <= 1'b0;
      else if (!in_set_nxt)
         blink <= 1'b0;
      else if (any_key)
         blink <= 1'b1;
      else if (tick_1hz)
         blink <= ~blink;
   end

   assign hour_set1 = hour_r[7:4];
   assign hour_set0 = hour_r[3:0];
   assign min_set1  = min_r[7:4];
   assign min_set0  = min_r[3:0];
   assign sec_set1  = sec_r[7:4];
   assign sec_set0  = sec_r[3:0];

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl; with SET_TIMEOUT_EN defined it
// also exercises auto-commit using TIMEOUT_S = 3.
module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       key_mode = 1'b0;
   logic       key_inc = 1'b0;
   logic       key_dec = 1'b0;
   logic [3:0] hour1 = '0, hour0 = '0;
   logic [3:0] min1 = '0, min0 = '0;
   logic [3:0] sec1 = '0, sec0 = '0;
   logic       set_mode, load, blink;
   logic [1:0] field;
   logic [3:0] hour_set1, hour_set0, min_set1;
   logic [3:0] min_set0, sec_set1, sec_set0;
   logic [23:0] setv;

   int vectors = 0;
   int miscompares = 0;

   assign setv = {hour_set1, hour_set0, min_set1,
                  min_set0, sec_set1, sec_set0};

   time_set_ctrl #(.TIMEOUT_S(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_1hz  (tick_1hz),
      .key_mode  (key_mode),
      .key_inc   (key_inc),
      .key_dec   (key_dec),
      .hour1     (hour1),
      .hour0     (hour0),
      .min1      (min1),
      .min0      (min0),
      .sec1      (sec1),
      .sec0      (sec0),
      .set_mode  (set_mode),
      .load      (load),
      .hour_set1 (hour_set1),
      .hour_set0 (hour_set0),
      .min_set1  (min_set1),
      .min_set0  (min_set0),
      .sec_set1  (sec_set1),
      .sec_set0  (sec_set0),
      .field     (field),
      .blink     (blink)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic m, input logic i,
                       input logic d, input logic t);
      key_mode = m;
      key_inc  = i;
      key_dec  = d;
      tick_1hz = t;
      @(posedge clk);
      #1;
      key_mode = 1'b0;
      key_inc  = 1'b0;
      key_dec  = 1'b0;
      tick_1hz = 1'b0;
   endtask

   task automatic set_time(input logic [23:0] v);
      {hour1, hour0, min1, min0, sec1, sec0} = v;
   endtask

   initial begin
      #1;
      chk("rst_set_mode", set_mode, 0);
      chk("rst_load", load, 0);
      chk("rst_field", field, 0);
      chk("rst_blink", blink, 0);
      chk("rst_setv", setv, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      set_time(24'h123456);
      step(1, 0, 0, 0);
      chk("cap_field", field, 1);
      chk("cap_set_mode", set_mode, 1);
      chk("cap_setv", setv, 24'h123456);
      chk("cap_blink", blink, 1);
      chk("cap_load", load, 0);
      set_time(24'h000000);
      step(0, 0, 0, 0);
      chk("hold_setv", setv, 24'h123456);
      step(0, 1, 0, 0);
      chk("inc_12", setv, 24'h133456);
      step(0, 0, 0, 1);
      chk("tick_blink", blink, 0);
      step(0, 0, 1, 0);
      chk("dec_13", setv, 24'h123456);
      chk("key_blink", blink, 1);
      step(1, 0, 0, 0);
      chk("adv_min", field, 2);
      step(1, 0, 0, 0);
      chk("adv_sec", field, 3);
      step(1, 1, 0, 0);
      chk("commit_load", load, 1);
      chk("commit_set_mode", set_mode, 1);
      chk("commit_field", field, 0);
      chk("commit_blink", blink, 0);
      chk("mode_beats_inc", setv, 24'h123456);
      step(0, 0, 0, 0);
      chk("post_load", load, 0);
      chk("post_set_mode", set_mode, 0);
      step(0, 1, 0, 0);
      chk("run_inc_ign", setv, 24'h123456);
      chk("run_field", field, 0);

      set_time(24'h230009);
      step(1, 0, 0, 0);
      chk("cap2", setv, 24'h230009);
      step(0, 1, 0, 0);
      chk("hour_wrap_up", setv, 24'h000009);
      step(0, 0, 1, 0);
      chk("hour_wrap_dn", setv, 24'h230009);
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      chk("min_wrap_dn", setv, 24'h235909);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("sec_carry", setv, 24'h235910);
      step(0, 1, 1, 0);
      chk("inc_dec_both", setv, 24'h235910);
      step(0, 0, 1, 0);
      chk("sec_borrow", setv, 24'h235909);
      step(1, 0, 0, 0);
      chk("commit2_load", load, 1);
      step(0, 0, 0, 0);
      chk("run2_load", load, 0);
      chk("run2_keep", setv, 24'h235909);

      set_time(24'h253A61);
      step(1, 0, 0, 0);
      chk("clamp", setv, 24'h000000);
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      chk("clamp_dec", setv, 24'h005900);
      chk("mid_field", field, 2);
      rst_n = 1'b0;
      #1;
      chk("arst_set_mode", set_mode, 0);
      chk("arst_field", field, 0);
      chk("arst_load", load, 0);
      chk("arst_blink", blink, 0);
      chk("arst_setv", setv, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0);
      chk("arst_noload", load, 0);
      chk("arst_run", set_mode, 0);

`ifdef SET_TIMEOUT_EN
      set_time(24'h102030);
      step(1, 0, 0, 0);
      step(0, 0, 0, 1);
      step(0, 1, 0, 1);
      chk("to_inc", setv, 24'h112030);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("to_restart", load, 0);
      chk("to_still_set", field, 1);
      step(0, 0, 0, 1);
      chk("to_load", load, 1);
      chk("to_keep", setv, 24'h112030);
      step(0, 0, 0, 0);
      chk("to_run", set_mode, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
